// File: rtl/playbus_pkg.sv
// rtl/playbus_pkg.sv - shared types and constants for the PlayBus instruction sequencer
//
// Purpose: state encoding, function-code type and instruction field layout
//          used by playbus_sequencer and its testbench.
// Ports:   none (package).

package playbus_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    EXEC1 = 3'd3,
    EXEC2 = 3'd4,
    HALT  = 3'd5
  } state_t;

  typedef logic [2:0] func_t;

  // Instruction byte layout: [7:5] function code, [4:0] operand.
  localparam int FUNC_MSB = 7;
  localparam int FUNC_LSB = 5;
  localparam int OPND_MSB = 4;

  // Function codes at or above this value need two execute cycles.
  localparam int DEFAULT_LONG_FUNC_MIN = 3;

endpackage

// File: rtl/playbus_sequencer.sv
// rtl/playbus_sequencer.sv - instruction fetch/issue stage feeding the PlayBus level 1 controller
//
// Purpose: fetches 8-bit instructions from a synchronous program ROM, latches
//          them in an instruction register and holds func/operand for the one
//          or two cycles the controller needs to execute the function.
// Ports:
//   clk        in   system clock, rising edge
//   n_reset    in   asynchronous active-low reset
//   run        in   1 allows fetching; 0 pauses at the next fetch boundary
//   instr_data in   ROM read data, valid one cycle after rom_addr
//   rom_addr   out  program ROM address (program counter)
//   func       out  function code to controller (IR[7:5])
//   operand    out  operand field (IR[4:0])
//   exec       out  high while func is being executed
//   halted     out  high once a non-wrapping program has finished

module playbus_sequencer
  import playbus_pkg::*;
#(
  parameter int PC_W          = 5,
  parameter int WRAP          = 1,
  parameter int LONG_FUNC_MIN = DEFAULT_LONG_FUNC_MIN
) (
  input  logic            clk,
  input  logic            n_reset,
  input  logic            run,
  input  logic [7:0]      instr_data,
  output logic [PC_W-1:0] rom_addr,
  output logic [2:0]      func,
  output logic [4:0]      operand,
  output logic            exec,
  output logic            halted
);

  localparam func_t           LONG_MIN = func_t'(LONG_FUNC_MIN);
  localparam logic [PC_W-1:0] PC_MAX   = {PC_W{1'b1}};
  localparam logic            WRAP_EN  = (WRAP != 0);

  state_t          state;
  state_t          state_next;
  logic [PC_W-1:0] pc;
  logic [7:0]      ir;
  // Set when the final address of a non-wrapping program has been loaded;
  // the PC is left pointing at that address so it stays frozen in HALT.
  logic            last;
  logic            is_long;
  state_t          exit_state;

  // func/operand come straight from IR, so they only move when IR is loaded
  // on the LOAD->EXEC1 edge and stay stable across a long function.
  assign func     = ir[FUNC_MSB:FUNC_LSB];
  assign operand  = ir[OPND_MSB:0];
  assign rom_addr = pc;
  assign is_long  = (func >= LONG_MIN);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= IDLE;
      pc    <= '0;
      ir    <= 8'h00;
      last  <= 1'b0;
    end else begin
      state <= state_next;
      if (state == LOAD) begin
        ir <= instr_data;
        if (!WRAP_EN && (pc == PC_MAX)) begin
          last <= 1'b1;
        end else begin
          pc <= pc + PC_W'(1);
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    exec       = 1'b0;
    halted     = 1'b0;

    // Common exit once an instruction has finished executing.
    if (last) begin
      exit_state = HALT;
    end else if (run) begin
      exit_state = FETCH;
    end else begin
      exit_state = IDLE;
    end

    unique case (state)
      IDLE: begin
        if (run) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        state_next = LOAD;
      end
      LOAD: begin
        state_next = EXEC1;
      end
      EXEC1: begin
        exec       = 1'b1;
        state_next = is_long ? EXEC2 : exit_state;
      end
      EXEC2: begin
        exec       = 1'b1;
        state_next = exit_state;
      end
      HALT: begin
        halted     = 1'b1;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_playbus_sequencer.sv
// tb/tb_playbus_sequencer.sv - directed self-checking bench for playbus_sequencer
//
// Purpose: three sequencer instances (PC_W=5 wrapping, PC_W=2 halting,
//          PC_W=2 wrapping), each fed by a 1-cycle-latency behavioural ROM.
// Ports:   none (top-level bench).

module tb_playbus_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A: PC_W=5, WRAP=1
  logic       rst_a, run_a, exec_a, halt_a;
  logic [7:0] data_a;
  logic [4:0] addr_a, opnd_a;
  logic [2:0] func_a;
  logic [7:0] rom_a [32];

  // Instance B: PC_W=2, WRAP=0
  logic       rst_b, run_b, exec_b, halt_b;
  logic [7:0] data_b;
  logic [1:0] addr_b;
  logic [4:0] opnd_b;
  logic [2:0] func_b;
  logic [7:0] rom_b [4];

  // Instance C: PC_W=2, WRAP=1
  logic       rst_c, run_c, exec_c, halt_c;
  logic [7:0] data_c;
  logic [1:0] addr_c;
  logic [4:0] opnd_c;
  logic [2:0] func_c;
  logic [7:0] rom_c [4];

  always @(posedge clk) data_a <= rom_a[addr_a];
  always @(posedge clk) data_b <= rom_b[addr_b];
  always @(posedge clk) data_c <= rom_c[addr_c];

  playbus_sequencer #(.PC_W(5), .WRAP(1), .LONG_FUNC_MIN(3)) dut_a (
    .clk(clk), .n_reset(rst_a), .run(run_a), .instr_data(data_a),
    .rom_addr(addr_a), .func(func_a), .operand(opnd_a), .exec(exec_a), .halted(halt_a)
  );

  playbus_sequencer #(.PC_W(2), .WRAP(0), .LONG_FUNC_MIN(3)) dut_b (
    .clk(clk), .n_reset(rst_b), .run(run_b), .instr_data(data_b),
    .rom_addr(addr_b), .func(func_b), .operand(opnd_b), .exec(exec_b), .halted(halt_b)
  );

  playbus_sequencer #(.PC_W(2), .WRAP(1), .LONG_FUNC_MIN(3)) dut_c (
    .clk(clk), .n_reset(rst_c), .run(run_c), .instr_data(data_c),
    .rom_addr(addr_c), .func(func_c), .operand(opnd_c), .exec(exec_c), .halted(halt_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_a();
    run_a = 1'b0;
    rst_a = 1'b0;
    step(2);
    rst_a = 1'b1;
  endtask

  initial begin
    int   cnt;
    int   width;
    int   pulses;
    int   cyc;
    int   last_cyc;
    int   n;
    logic stable;
    logic [7:0] v;

    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    run_a = 1'b0; run_b = 1'b0; run_c = 1'b0;
    for (int i = 0; i < 32; i++) rom_a[i] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      v = 8'(i);
      rom_b[i] = 8'h20 | v;
      rom_c[i] = 8'h20 | v;
    end

    // ---- Test 1: reset state, single short instruction ----
    rom_a[0] = 8'h21;
    reset_a();
    chk("rst_addr", addr_a, 0);
    chk("rst_func", func_a, 0);
    chk("rst_opnd", opnd_a, 0);
    chk("rst_exec", exec_a, 0);
    chk("rst_halt", halt_a, 0);
    run_a = 1'b1;
    step(1);
    chk("t1_fetch_exec", exec_a, 0);
    chk("t1_fetch_addr", addr_a, 0);
    step(1);
    chk("t1_load_exec", exec_a, 0);
    step(1);
    chk("t1_exec", exec_a, 1);
    chk("t1_func", func_a, 1);
    chk("t1_opnd", opnd_a, 1);
    chk("t1_addr", addr_a, 1);
    run_a = 1'b0;
    step(1);
    chk("t1_exec_drop", exec_a, 0);
    chk("t1_idle_addr", addr_a, 1);
    step(2);
    chk("t1_idle_exec", exec_a, 0);

    // ---- Test 2: long instruction then short ----
    rom_a[0] = 8'h65;
    rom_a[1] = 8'h21;
    reset_a();
    run_a = 1'b1;
    step(3);
    chk("t2_e1_exec", exec_a, 1);
    chk("t2_e1_func", func_a, 3);
    chk("t2_e1_opnd", opnd_a, 5);
    step(1);
    chk("t2_e2_exec", exec_a, 1);
    chk("t2_e2_func", func_a, 3);
    chk("t2_e2_opnd", opnd_a, 5);
    step(1);
    chk("t2_fetch_exec", exec_a, 0);
    chk("t2_fetch_addr", addr_a, 1);
    chk("t2_fetch_func_hold", func_a, 3);
    run_a = 1'b0;
    step(2);
    chk("t2_next_exec", exec_a, 1);
    chk("t2_next_func", func_a, 1);
    step(1);
    chk("t2_idle_exec", exec_a, 0);
    chk("t2_idle_addr", addr_a, 2);

    // ---- Test 3: func 0..7 pulse widths ----
    for (int i = 0; i < 8; i++) begin
      v = 8'(i);
      rom_a[i] = {v[2:0], v[4:0]};
    end
    reset_a();
    run_a = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cnt = 0;
      while (exec_a !== 1'b1 && cnt < 10) begin
        step(1);
        cnt++;
      end
      chk("t3_start_seen", (cnt < 10), 1);
      chk("t3_func_order", func_a, k);
      if (k == 7) run_a = 1'b0;
      width  = 0;
      stable = 1'b1;
      while (exec_a === 1'b1 && width < 5) begin
        if (func_a !== 3'(k)) stable = 1'b0;
        width++;
        step(1);
      end
      chk("t3_width", width, (k >= 3) ? 2 : 1);
      chk("t3_func_stable", stable, 1);
    end
    step(2);
    chk("t3_end_exec", exec_a, 0);
    chk("t3_end_addr", addr_a, 8);
    chk("t3_end_halt", halt_a, 0);

    // ---- Test 7: run dropped during EXEC1 of a long instruction ----
    rom_a[0] = 8'hA3;
    rom_a[1] = 8'h21;
    reset_a();
    run_a = 1'b1;
    step(3);
    chk("t7_e1_exec", exec_a, 1);
    chk("t7_e1_func", func_a, 5);
    run_a = 1'b0;
    step(1);
    chk("t7_e2_exec", exec_a, 1);
    chk("t7_e2_func", func_a, 5);
    step(1);
    chk("t7_idle_exec", exec_a, 0);
    chk("t7_idle_addr", addr_a, 1);
    step(3);
    chk("t7_still_idle", exec_a, 0);
    chk("t7_still_addr", addr_a, 1);

    // ---- Test 6: reset asserted during EXEC2 of func 5 ----
    reset_a();
    run_a = 1'b1;
    step(4);
    chk("t6_e2_exec", exec_a, 1);
    rst_a = 1'b0;
    #1;
    chk("t6_async_exec", exec_a, 0);
    chk("t6_async_func", func_a, 0);
    chk("t6_async_opnd", opnd_a, 0);
    chk("t6_async_addr", addr_a, 0);
    step(1);
    rst_a = 1'b1;
    step(1);
    chk("t6_refetch_addr", addr_a, 0);
    chk("t6_refetch_exec", exec_a, 0);
    step(2);
    chk("t6_re_exec", exec_a, 1);
    chk("t6_re_func", func_a, 5);
    chk("t6_re_opnd", opnd_a, 3);
    run_a = 1'b0;

    // ---- Test 4: WRAP=0 halts after last address ----
    step(1);
    rst_b = 1'b1;
    step(1);
    run_b  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (exec_b === 1'b1) pulses++;
    end
    chk("t4_pulses", pulses, 4);
    chk("t4_halted", halt_b, 1);
    chk("t4_exec", exec_b, 0);
    chk("t4_addr", addr_b, 3);
    for (int j = 0; j < 6; j++) begin
      run_b = j[0];
      step(1);
      chk("t4_hold_halt", halt_b, 1);
      chk("t4_hold_exec", exec_b, 0);
      chk("t4_hold_addr", addr_b, 3);
    end

    // ---- Test 5: WRAP=1 runs on from address 3 to 0 ----
    rst_c = 1'b1;
    step(1);
    run_c    = 1'b1;
    cyc      = 0;
    last_cyc = 0;
    n        = 0;
    for (int i = 0; i < 25; i++) begin
      step(1);
      cyc++;
      if (exec_c === 1'b1) begin
        chk("t5_opnd", opnd_c, n % 4);
        if (n > 0) chk("t5_spacing", cyc - last_cyc, 3);
        if ((n % 4) == 3) chk("t5_wrap_addr", addr_c, 0);
        last_cyc = cyc;
        n++;
      end
    end
    chk("t5_count", n, 8);
    chk("t5_not_halted", halt_c, 0);
    run_c = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
